// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: diff = a - b - borrow_in, SLICE bits per clock
// through a registered borrow chain, with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW     = SLICE + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_s, b_s;
  logic [SW-1:0]    slice_res;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    brw_d        = brw_q;
    k_d          = k_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    a_s          = '0;
    b_s          = '0;

    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (KW'(i) == k_q) begin
        a_s = a_q[i*SLICE +: SLICE];
        b_s = b_q[i*SLICE +: SLICE];
      end
    end
    // Extra top bit of the widened difference is the borrow out of this slice
    slice_res = {1'b0, a_s} - {1'b0, b_s} - SW'(brw_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = borrow_in;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (KW'(i) == k_q) diff_d[i*SLICE +: SLICE] = slice_res[SLICE-1:0];
        end
        brw_d = slice_res[SLICE];
        if (k_q == K_LAST) begin
          state_d      = DONE;
          borrow_out_d = slice_res[SLICE];
          overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d       = (diff_d == '0);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      brw_q        <= 1'b0;
      k_q          <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      brw_q        <= brw_d;
      k_q          <= k_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes model results on accept,
// a negedge monitor pops and compares on each output handshake.
module tb_serial_subtractor;

  localparam int unsigned W  = 8;
  localparam int unsigned NS = 8;   // WIDTH/SLICE for the main instance

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, borrow_in = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, borrow_out, overflow, zero;
  logic [W-1:0] diff;

  logic in_valid4 = 1'b0, borrow_in4 = 1'b0;
  logic [W-1:0] a4 = '0, b4 = '0;
  logic in_ready4, out_valid4, borrow_out4, overflow4, zero4;
  logic [W-1:0] diff4;

  int compared = 0, mismatched = 0, cyc = 0;
  exp_t sb_q[$];
  bit seen = 0;
  bit rand_ready = 0;

  serial_subtractor #(.WIDTH(8), .SLICE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
    .overflow(overflow), .zero(zero));

  serial_subtractor #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .borrow_in(borrow_in4), .out_valid(out_valid4),
    .out_ready(1'b1), .diff(diff4), .borrow_out(borrow_out4),
    .overflow(overflow4), .zero(zero4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the unsigned and signed views
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    exp_t e;
    int r, sr;
    r      = int'(ia) - int'(ib) - int'(ibin);
    sr     = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
    e.diff = W'(r);
    e.bout = (r < 0);
    e.ovf  = (sr < -128) || (sr > 127);
    e.zero = (e.diff == '0);
    e.acc  = 0;
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        timeout("unexpected_out_valid");
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", 32'(cyc - sb_q[0].acc), NS);
        end
        if (out_ready) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("diff", 32'(diff), 32'(e.diff));
          chk("borrow_out", 32'(borrow_out), 32'(e.bout));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("zero", 32'(zero), 32'(e.zero));
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    exp_t e;
    int n;
    n = 0;
    @(posedge clk); #1;
    a = ia; b = ib; borrow_in = ibin; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        timeout("accept");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    e = model(ia, ib, ibin);
    e.acc = cyc;
    sb_q.push_back(e);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb_q.size() != 0; n++) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (sb_q.size() != 0) begin
      timeout("drain");
      sb_q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] dir_a [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h10};
    logic [W-1:0] dir_b [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h10};
    logic         dir_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] hd;
    logic hb, ho, hz;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_flags", {29'd0, borrow_out, overflow, zero}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(dir_a[i], dir_b[i], dir_c[i]);
      drain();
    end

    // Backpressure: hold out_ready low, offer a competing operation meanwhile
    out_ready = 1'b0;
    issue(8'h5C, 8'h21, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) timeout("bp_valid");
    hd = diff; hb = borrow_out; ho = overflow; hz = zero;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'hEE; b = 8'h11;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_diff_stable", 32'(diff), 32'(hd));
      chk("bp_flags_stable", {29'd0, borrow_out, overflow, zero}, {29'd0, hb, ho, hz});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    drain();

    // Abort in the third RUN cycle
    issue(8'h77, 8'h12, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_diff", 32'(diff), 0);
    sb_q.delete();
    seen = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    issue(8'h05, 8'h03, 1'b0);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      drain();
    end
    rand_ready = 0;
    out_ready = 1'b1;

    // SLICE=4 instance: two RUN cycles
    @(posedge clk); #1;
    a4 = 8'hA5; b4 = 8'h5A; borrow_in4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    chk("s4_in_ready", 32'(in_ready4), 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 8'h00; b4 = 8'hFF;
    @(posedge clk); #1;
    chk("s4_not_yet_valid", 32'(out_valid4), 0);
    @(posedge clk); #1;
    chk("s4_out_valid", 32'(out_valid4), 1);
    chk("s4_diff", 32'(diff4), 32'(model(8'hA5, 8'h5A, 1'b0).diff));
    chk("s4_borrow_out", 32'(borrow_out4), 0);
    chk("s4_overflow", 32'(overflow4), 1);
    @(posedge clk); #1;
    chk("s4_back_idle", 32'(in_ready4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
